// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and helpers for the parallel-in / serial-out transmitter.
//   state_t    : transmitter FSM encoding (IDLE, SHIFT, DONE)
//   cnt_width(): bit width of a counter that must hold values 0..n
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Width of a counter able to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_shift_transmitter_bit_tick_counter.sv
// -----------------------------------------------------------------------------
// bit_tick_counter
// Paces how long each serial bit is held: counts enabled cycles modulo
// BIT_TICKS and flags the last tick of a bit period.
// Ports:
//   clock    in  rising-edge clock
//   resetp   in  asynchronous active-high reset
//   clear    in  restart the bit period (synchronous)
//   enable   in  count this cycle
//   terminal out high when count == BIT_TICKS-1 and enable is high
// -----------------------------------------------------------------------------
module bit_tick_counter
    import piso_pkg::*;
#(
    parameter int BIT_TICKS = 1
) (
    input  logic clock,
    input  logic resetp,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int TW = cnt_width(BIT_TICKS);

    logic [TW-1:0] r_cnt;
    logic          w_last;

    assign w_last   = (r_cnt == TW'(BIT_TICKS - 1));
    assign terminal = enable && w_last;

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            r_cnt <= '0;
        end else if (clear || terminal) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_shift_transmitter.sv
// -----------------------------------------------------------------------------
// piso_shift_transmitter
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on
// a single serial line, each bit held for BIT_TICKS enabled cycles.
// Optional build macro: PISO_PARITY_EN appends one even-parity bit (XOR of
// the captured word) after the data bits.
// Ports:
//   clock      in   rising-edge clock
//   resetp     in   asynchronous active-high reset
//   d          in   parallel word to transmit
//   load_valid in   source presents a word on d
//   load_ready out  high in IDLE; handshake on load_valid & load_ready
//   enable     in   advance enable while shifting (ignored in IDLE/DONE)
//   sout       out  serial data, 0 outside a frame
//   sframe     out  high while data/parity bits are on sout
//   done       out  one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module piso_shift_transmitter
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BIT_TICKS = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clock,
    input  logic             resetp,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enable,
    output logic             sout,
    output logic             sframe,
    output logic             done
);

    localparam int BW = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit;
    logic             w_hs;
    logic             w_tick_en;
    logic             w_term;
    logic             w_last_bit;
    logic             w_data_head;
    logic             w_head;

    assign w_hs       = (r_state == IDLE) && load_valid;
    assign w_tick_en  = (r_state == SHIFT) && enable;
    assign w_last_bit = (r_bit == BW'(NBITS - 1));

    bit_tick_counter #(
        .BIT_TICKS(BIT_TICKS)
    ) u_tick (
        .clock   (clock),
        .resetp  (resetp),
        .clear   (w_hs),
        .enable  (w_tick_en),
        .terminal(w_term)
    );

    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = SHIFT;
            SHIFT:   if (w_term && w_last_bit) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The head bit is always at a fixed end; shifting moves the next bit
    // into it and zero-fills the far end.
    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            r_shreg <= '0;
            r_bit   <= '0;
        end else if (w_hs) begin
            r_shreg <= d;
            r_bit   <= '0;
        end else if (w_term && !w_last_bit) begin
            r_bit <= r_bit + 1'b1;
            if (MSB_FIRST != 0) r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            else                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    assign w_data_head = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];

`ifdef PISO_PARITY_EN
    logic r_par;

    // Parity is taken from the word as captured, not from the draining shreg.
    always_ff @(posedge clock or posedge resetp) begin
        if (resetp) begin
            r_par <= 1'b0;
        end else if (w_hs) begin
            r_par <= ^d;
        end
    end

    assign w_head = (r_bit == BW'(WIDTH)) ? r_par : w_data_head;
`else
    assign w_head = w_data_head;
`endif

    assign load_ready = (r_state == IDLE);
    assign sframe     = (r_state == SHIFT);
    assign done       = (r_state == DONE);
    assign sout       = sframe && w_head;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_transmitter
// Two transmitters side by side: lane 0 (BIT_TICKS=1, LSB first) and lane 1
// (BIT_TICKS=3, MSB first). Accepted words go into a per-lane queue; a monitor
// per lane rebuilds the expected serial frame from the word and compares it
// cycle by cycle against sout/sframe/done/load_ready.
// -----------------------------------------------------------------------------
module tb_piso_shift_transmitter;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = W + PAR;

    typedef struct {
        logic [W-1:0] w;
        time          t;
    } ent_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit fin [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int BT  = (g == 0) ? 1 : 3;
        localparam int MSB = (g == 1) ? 1 : 0;

        logic         resetp     = 1'b1;
        logic         load_valid = 1'b0;
        logic         enable     = 1'b0;
        logic [W-1:0] d          = '0;
        logic         load_ready, sout, sframe, done;

        piso_shift_transmitter #(
            .WIDTH(W), .BIT_TICKS(BT), .MSB_FIRST(MSB)
        ) dut (
            .clock(clock), .resetp(resetp), .d(d), .load_valid(load_valid),
            .load_ready(load_ready), .enable(enable), .sout(sout),
            .sframe(sframe), .done(done)
        );

        ent_t         q[$];
        int           phase = 0;
        int           p     = 0;
        logic [W-1:0] cur;

        // Reference: bit k of the frame is data bit k in shift order, then parity.
        function automatic logic exp_bit(input logic [W-1:0] w, input int idx);
            if (idx >= W) return ^w;
            return (MSB != 0) ? w[W-1-idx] : w[idx];
        endfunction

        // Monitor. enable seen at a negedge is the value applied at the next
        // posedge, so p counts enabled cycles of the frame.
        always @(negedge clock) begin
            ent_t e;
            if (resetp) begin
                q.delete();
                phase = 0;
                p     = 0;
            end else begin
                if (phase == 0) begin
                    if (q.size() != 0 && q[0].t < $time) begin
                        e   = q.pop_front();
                        cur = e.w;
                        chk("frame_start", sframe, 1);
                        if (sframe) begin
                            p     = 0;
                            phase = 1;
                        end
                    end else begin
                        chk("idle_ready", load_ready, 1);
                        chk("idle_sframe", sframe, 0);
                        chk("idle_done", done, 0);
                        chk("idle_sout", sout, 0);
                    end
                end else if (phase == 2) begin
                    chk("done_pulse", done, 1);
                    chk("done_sframe", sframe, 0);
                    chk("done_sout", sout, 0);
                    chk("done_ready", load_ready, 0);
                    phase = 3;
                end else if (phase == 3) begin
                    chk("post_ready", load_ready, 1);
                    chk("post_done", done, 0);
                    chk("post_sframe", sframe, 0);
                    phase = 0;
                end
                if (phase == 1) begin
                    chk("shift_sframe", sframe, 1);
                    chk("shift_sout", sout, exp_bit(cur, p / BT));
                    chk("shift_ready", load_ready, 0);
                    chk("shift_done", done, 0);
                    if (enable) p++;
                    if (p == NB * BT) phase = 2;
                end
            end
        end

        // One clock: detect a handshake ahead of the posedge (inputs and
        // load_ready are stable from negedge to posedge), then re-roll enable.
        task automatic cyc(input int en_pct, output bit hs);
            hs = 1'b0;
            @(negedge clock);
            if (!resetp && load_valid && load_ready) begin
                q.push_back('{d, $time});
                hs = 1'b1;
            end
            @(posedge clock);
            #1 enable = ($urandom_range(99) < en_pct);
        endtask

        task automatic send(input logic [W-1:0] w, input int en_pct, input bit keep);
            bit hs;
            int guard;
            d          = w;
            load_valid = 1'b1;
            hs         = 1'b0;
            guard      = 0;
            while (!hs && guard < 300) begin
                cyc(en_pct, hs);
                guard++;
            end
            if (!hs) chk("handshake_timeout", 0, 1);
            if (!keep) load_valid = 1'b0;
        endtask

        task automatic drain(input int en_pct);
            bit hs;
            int guard;
            guard = 0;
            do begin
                cyc(en_pct, hs);
                guard++;
            end while (!(phase == 0 && q.size() == 0) && guard < 500);
            if (guard >= 500) chk("drain_timeout", 0, 1);
        endtask

        initial begin
            bit hs;
            #2;
            chk("rst_ready", load_ready, 1);
            chk("rst_sframe", sframe, 0);
            chk("rst_done", done, 0);
            chk("rst_sout", sout, 0);
            repeat (2) @(posedge clock);
            #1 resetp = 1'b0;
            enable = 1'b1;

            send(8'hA5, 100, 0); drain(100);
            send(8'h01, 100, 0); drain(100);
            send(8'h07, 100, 0); drain(100);
            send(8'h0F, 60, 0);  drain(60);

            // Abort a frame mid-flight; outputs must fall without a clock edge.
            send(8'h3C, 100, 0);
            repeat (3) cyc(100, hs);
            resetp = 1'b1;
            #1;
            chk("abort_sout", sout, 0);
            chk("abort_sframe", sframe, 0);
            chk("abort_done", done, 0);
            chk("abort_ready", load_ready, 1);
            cyc(100, hs);
            resetp = 1'b0;
            repeat (3) cyc(100, hs);
            send(8'h96, 100, 0); drain(100);

            // load_valid held high with alternating words.
            for (int i = 0; i < 6; i++) send((i % 2) ? 8'h00 : 8'hFF, 100, i < 5);
            drain(100);

            for (int i = 0; i < 40; i++) begin
                send(W'($urandom), 70, bit'($urandom_range(1)));
                if (!load_valid) repeat ($urandom_range(3)) cyc(70, hs);
            end
            load_valid = 1'b0;
            drain(70);
            fin[g] = 1'b1;
        end
    end

    initial begin
        fork
            begin wait (fin[0] && fin[1]); end
            begin #600000; end
        join_any
        disable fork;
        chk("run_complete", (fin[0] && fin[1]) ? 1 : 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
